aes_key_expand128: RTL
======================

AES_KEY_EXPAND128 -- requirements
Module: aes_key_expand128

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to expand key; sampled only when ready=1.
REQ-005 key  input  128  AES-128 cipher key, word w0 = key[127:96]; sampled on the accepting edge only.
REQ-006 sboxw  output  32  RotWord of the working key's last word, sent to the external key-expansion S-box.
REQ-007 new_sboxw  input  32  SubWord(sboxw) from the external combinational S-box, same cycle.
REQ-008 ready  output  1  idle, can accept start.
REQ-009 keys_valid  output  1  all 11 round keys stored for the last accepted key.
REQ-010 rk_addr  input  4  round-key read index, 0..10.
REQ-011 rk_data  output  128  registered round key read at rk_addr.

Function
REQ-012 FSM states SHALL be IDLE and GEN; reset enters IDLE.
REQ-013 In IDLE, ready SHALL be 1; in GEN, ready SHALL be 0.
REQ-014 On the edge with start=1 and ready=1, the block SHALL load working key <= key, write mem[0] <= key, set round counter to 1, clear keys_valid, and enter GEN.
REQ-015 start while ready=0 SHALL be ignored: no restart and no change to the round counter or key.
REQ-016 sboxw SHALL always equal {w3[23:0], w3[31:24]} of the working key, where w3 = working key [31:0]; this path is combinational.
REQ-017 Per GEN cycle, t SHALL be new_sboxw XOR {rcon(r),24'h0}, with r = current round counter.
REQ-018 The next key words SHALL be n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
REQ-019 rcon(1..10) SHALL be 01,02,04,08,10,20,40,80,1b,36 (hex).
REQ-020 On each GEN edge, the block SHALL write mem[r] and the working key with the next key, and increment r.
REQ-021 When r=10 is written, the FSM SHALL return to IDLE, set ready=1 and set keys_valid=1 on that same edge.
REQ-022 Latency SHALL be 11 edges from the accepting edge to keys_valid=1: 1 load edge plus 10 GEN edges.
REQ-023 A start on the first edge with ready=1 again SHALL be accepted (back-to-back operation); keys_valid then drops to 0.
REQ-024 The round counter SHALL be 4 bits; values 11..15 SHALL be unreachable and SHALL force IDLE if entered.
REQ-025 rk_data SHALL be mem[rk_addr] registered with 1-cycle latency; rk_addr 11..15 SHALL return all-zero.
REQ-026 Reads during GEN SHALL be allowed and return current memory contents; data SHALL be guaranteed correct only while keys_valid=1.
REQ-027 The 11x128 round-key storage SHALL NOT be reset.

Reset
REQ-028 When reset=1, the block SHALL asynchronously force state=IDLE, ready=1, keys_valid=0, rk_data=0, round counter=0 and working key=0.
REQ-029 Reset asserted mid-GEN SHALL abort the expansion; after release, keys_valid SHALL stay 0 until a new expansion completes.
REQ-030 The first start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-031 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse -> after 11 edges keys_valid=1; rk_addr=1 gives a0fafe1788542cb123a339392a6c7605; rk_addr=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-032 All-zero key -> rk_addr=0 gives 0; rk_addr=1 gives 62636363626363636263636362636363; rk_addr=10 gives b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-033 Start with key A, then start with key B held high throughout GEN -> B ignored; results match A; B is accepted on the edge where ready returns to 1.
REQ-034 Reset pulse at GEN round 5 -> ready=1 and keys_valid=0 immediately; a subsequent FIPS key expansion gives correct round 10.
REQ-035 rk_addr=11 and rk_addr=15 with keys_valid=1 -> rk_data=0 one cycle later; rk_addr=0 -> the loaded key one cycle later.
REQ-036 Cycle checker: sboxw equals the rotated w3 every cycle; ready=0 for exactly 10 cycles per accepted start.

Source files
------------

// File: rtl/aes_key_expand128.sv
// AES-128 key expansion: one round key per clock, 11 keys stored for
// random-access readback. The S-box lives outside; sboxw goes out and
// new_sboxw = SubWord(sboxw) comes back in the same cycle.
module aes_key_expand128 (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] key,
   output logic [31:0]  sboxw,
   input  logic [31:0]  new_sboxw,
   output logic         ready,
   output logic         keys_valid,
   input  logic [3:0]   rk_addr,
   output logic [127:0] rk_data
);

   typedef enum logic {IDLE = 1'b0, GEN = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [3:0]     round_q, round_d;
   logic [127:0]   wkey_q, wkey_d;
   logic           kv_q, kv_d;
   logic [127:0]   rk_data_q;

   // Round-key storage, deliberately without reset.
   logic [127:0]   mem [0:10];
   logic           mem_we;
   logic [3:0]     mem_waddr;
   logic [127:0]   mem_wdata;

   logic [31:0]    w0, w1, w2, w3, t, n0, n1, n2, n3;
   logic [127:0]   next_key;

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   assign w0 = wkey_q[127:96];
   assign w1 = wkey_q[95:64];
   assign w2 = wkey_q[63:32];
   assign w3 = wkey_q[31:0];

   // RotWord of the last working word, straight out to the S-box.
   assign sboxw = {w3[23:0], w3[31:24]};

   // One round of the key schedule from the S-box result.
   always_comb begin
      t  = new_sboxw ^ {rcon(round_q), 24'h0};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      next_key = {n0, n1, n2, n3};
   end

   assign ready      = (state_q == IDLE);
   assign keys_valid = kv_q;
   assign rk_data    = rk_data_q;

   // Next-state logic: accept in IDLE, one round per cycle in GEN.
   always_comb begin
      state_d   = state_q;
      round_d   = round_q;
      wkey_d    = wkey_q;
      kv_d      = kv_q;
      mem_we    = 1'b0;
      mem_waddr = 4'd0;
      mem_wdata = next_key;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = GEN;
               round_d   = 4'd1;
               wkey_d    = key;
               kv_d      = 1'b0;
               mem_we    = 1'b1;
               mem_waddr = 4'd0;
               mem_wdata = key;
            end
         end
         GEN: begin
            if (round_q >= 4'd1 && round_q <= 4'd10) begin
               wkey_d    = next_key;
               mem_we    = 1'b1;
               mem_waddr = round_q;
               round_d   = round_q + 4'd1;
               if (round_q == 4'd10) begin
                  // Last key written: park the counter at 0 so 11..15 never occur.
                  state_d = IDLE;
                  kv_d    = 1'b1;
                  round_d = 4'd0;
               end
            end else begin
               // Illegal counter value: abandon and return to IDLE.
               state_d = IDLE;
               round_d = 4'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and working-key registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         round_q <= 4'd0;
         wkey_q  <= 128'h0;
         kv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         wkey_q  <= wkey_d;
         kv_q    <= kv_d;
      end
   end

   // Round-key memory write port.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Registered read port; addresses past 10 read as zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 rk_data_q <= 128'h0;
      else if (rk_addr <= 4'd10) rk_data_q <= mem[rk_addr];
      else                       rk_data_q <= 128'h0;
   end

endmodule
